// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset/step constants and fetch state encoding for the fetch unit.
package inst_fetch_pkg;
    localparam int unsigned BUS_WIDTH = 32;
    localparam logic [BUS_WIDTH-1:0] RESET_PC = BUS_WIDTH'(32'h0000_0000);
    localparam logic [BUS_WIDTH-1:0] PC_STEP = BUS_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [BUS_WIDTH-1:0] inst;
        logic [BUS_WIDTH-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory req/ack port between the fetch unit and instruction memory.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic                 imem_req;
    logic [BUS_WIDTH-1:0] imem_addr;
    logic                 imem_ack;
    logic [BUS_WIDTH-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/inst_skid_buf.sv
// One-entry instruction+pc holding buffer for data that returns while the pipeline is stalled.
module inst_skid_buf
    import inst_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_if,
    input  logic         load,
    input  logic         drain,
    input  logic         flush,
    input  fetch_entry_t load_entry,
    output fetch_entry_t entry,
    output logic         full
);

    // Flush beats load; load beats drain.
    always_ff @(posedge clk) begin
        if (rst_if || flush) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= load_entry;
        end else if (drain) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues imem requests, presents instructions
// to the instruction register with stall holding and redirect flushing.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_if,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [BUS_WIDTH-1:0] redirect_pc,
    inst_fetch_if.master         imem,
    output logic [BUS_WIDTH-1:0] inst_out,
    output logic [BUS_WIDTH-1:0] pc_out,
    output logic                 inst_valid
);

    fetch_state_e         state_q, state_n;
    logic [BUS_WIDTH-1:0] pc_q, pc_n;
    logic                 req_q, req_n;
    logic [BUS_WIDTH-1:0] addr_q, addr_n;
    logic [BUS_WIDTH-1:0] inst_n, pc_out_n;
    logic                 valid_n;
    logic [BUS_WIDTH-1:0] seq_pc;
    logic [BUS_WIDTH-1:0] discard_target;
    logic                 skid_load, skid_drain, skid_flush, skid_full;
    fetch_entry_t         skid_in, skid_entry;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign seq_pc         = addr_q + PC_STEP;
    assign discard_target = redirect ? redirect_pc : pc_q;
    assign skid_in        = '{inst: imem.imem_rdata, pc: addr_q};

    inst_skid_buf u_skid (
        .clk        (clk),
        .rst_if     (rst_if),
        .load       (skid_load),
        .drain      (skid_drain),
        .flush      (skid_flush),
        .load_entry (skid_in),
        .entry      (skid_entry),
        .full       (skid_full)
    );

    always_ff @(posedge clk) begin
        if (rst_if) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
            inst_out   <= '0;
            pc_out     <= '0;
            inst_valid <= 1'b0;
        end else begin
            state_q    <= state_n;
            pc_q       <= pc_n;
            req_q      <= req_n;
            addr_q     <= addr_n;
            inst_out   <= inst_n;
            pc_out     <= pc_out_n;
            inst_valid <= valid_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        pc_n       = pc_q;
        req_n      = req_q;
        addr_n     = addr_q;
        inst_n     = inst_out;
        pc_out_n   = pc_out;
        valid_n    = stall ? inst_valid : 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_flush = 1'b0;

        // Redirect flushes presented and buffered data regardless of stall or ack.
        if (redirect) begin
            skid_flush = 1'b1;
            valid_n    = 1'b0;
            inst_n     = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    pc_n = redirect_pc;
                    if (!stall) begin
                        addr_n  = redirect_pc;
                        req_n   = 1'b1;
                        state_n = ST_REQ;
                    end
                end else if (!stall) begin
                    if (skid_full) begin
                        inst_n     = skid_entry.inst;
                        pc_out_n   = skid_entry.pc;
                        valid_n    = 1'b1;
                        skid_drain = 1'b1;
                    end
                    addr_n  = pc_q;
                    req_n   = 1'b1;
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem.imem_ack) begin
                    if (redirect) begin
                        pc_n = redirect_pc;
                        if (!stall) begin
                            addr_n = redirect_pc;
                        end else begin
                            req_n   = 1'b0;
                            state_n = ST_IDLE;
                        end
                    end else begin
                        pc_n = seq_pc;
                        if (!stall) begin
                            inst_n   = imem.imem_rdata;
                            pc_out_n = addr_q;
                            valid_n  = 1'b1;
                            addr_n   = seq_pc;
                        end else begin
                            skid_load = 1'b1;
                            req_n     = 1'b0;
                            state_n   = ST_IDLE;
                        end
                    end
                end else if (redirect) begin
                    pc_n    = redirect_pc;
                    state_n = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                pc_n = discard_target;
                // Stale data is dropped; the new target is fetched once the old beat retires.
                if (imem.imem_ack) begin
                    if (!stall) begin
                        addr_n  = discard_target;
                        state_n = ST_REQ;
                    end else begin
                        req_n   = 1'b0;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch with a programmable-latency instruction memory model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic                 clk;
    logic                 rst_if;
    logic                 stall;
    logic                 redirect;
    logic [BUS_WIDTH-1:0] redirect_pc;
    logic [BUS_WIDTH-1:0] inst_out;
    logic [BUS_WIDTH-1:0] pc_out;
    logic                 inst_valid;

    int errors = 0;
    int checks = 0;

    bit mem_auto;
    bit man_ack;
    int mem_lat;
    int lat_cnt;

    inst_fetch_if bus ();

    inst_fetch dut (
        .clk         (clk),
        .rst_if      (rst_if),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .inst_out    (inst_out),
        .pc_out      (pc_out),
        .inst_valid  (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ack after mem_lat request cycles, or a manually driven ack.
    assign bus.imem_ack   = mem_auto ? (bus.imem_req && (lat_cnt == mem_lat - 1)) : man_ack;
    assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (rst_if || !bus.imem_req || bus.imem_ack) lat_cnt <= 0;
        else lat_cnt <= lat_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset(input int lat, input bit auto_mode);
        rst_if = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        man_ack = 1'b0; mem_lat = lat; mem_auto = auto_mode;
        tick; tick;
        rst_if = 1'b0;
    endtask

    task automatic test_reset;
        rst_if = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        man_ack = 1'b0; mem_lat = 1; mem_auto = 1'b1;
        tick; tick;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", bus.imem_addr); end
        checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h exp 0", inst_out); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h exp 0", pc_out); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", inst_valid); end
        rst_if = 1'b0;
    endtask

    task automatic test_zero_wait;
        logic [31:0] exp_pc;
        apply_reset(1, 1'b1);
        tick;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL zw_first_req: req=%b addr=%h valid=%b exp 1/0/0", bus.imem_req, bus.imem_addr, inst_valid);
        end
        for (int k = 0; k < 6; k++) begin
            tick;
            exp_pc = 32'(4 * k);
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d]: got %b exp 1", k, inst_valid); end
            checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL zw_pc_out[%0d]: got %h exp %h", k, pc_out, exp_pc); end
            checks++; if (inst_out !== (exp_pc ^ 32'hA5A5_0000)) begin
                errors++; $display("FAIL zw_inst[%0d]: got %h exp %h", k, inst_out, exp_pc ^ 32'hA5A5_0000);
            end
            checks++; if (bus.imem_addr !== exp_pc + 32'd4) begin
                errors++; $display("FAIL zw_addr[%0d]: got %h exp %h", k, bus.imem_addr, exp_pc + 32'd4);
            end
        end
    endtask

    task automatic test_latency3;
        logic        exp_valid;
        logic [31:0] exp_addr;
        apply_reset(3, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            tick;
            exp_valid = (i >= 4) && (i % 3 == 1);
            exp_addr  = 32'(4 * ((i - 1) / 3));
            checks++; if (inst_valid !== exp_valid) begin errors++; $display("FAIL lat3_valid[%0d]: got %b exp %b", i, inst_valid, exp_valid); end
            checks++; if (bus.imem_addr !== exp_addr) begin errors++; $display("FAIL lat3_addr[%0d]: got %h exp %h", i, bus.imem_addr, exp_addr); end
            if (exp_valid) begin
                checks++; if (pc_out !== exp_addr - 32'd4) begin
                    errors++; $display("FAIL lat3_pc_out[%0d]: got %h exp %h", i, pc_out, exp_addr - 32'd4);
                end
            end
        end
    endtask

    task automatic test_stall;
        apply_reset(1, 1'b1);
        tick; tick; tick;
        checks++; if (bus.imem_addr !== 32'h8 || pc_out !== 32'h4) begin
            errors++; $display("FAIL stall_pre: addr=%h pc_out=%h exp 8/4", bus.imem_addr, pc_out);
        end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b exp 0", i, bus.imem_req); end
            checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h4 || inst_out !== 32'hA5A5_0004) begin
                errors++; $display("FAIL stall_hold[%0d]: valid=%b pc_out=%h inst=%h exp 1/4/a5a50004", i, inst_valid, pc_out, inst_out);
            end
        end
        stall = 1'b0;
        tick;
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h8 || inst_out !== 32'hA5A5_0008) begin
            errors++; $display("FAIL stall_skid_out: valid=%b pc_out=%h inst=%h exp 1/8/a5a50008", inst_valid, pc_out, inst_out);
        end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
            errors++; $display("FAIL stall_relaunch: req=%b addr=%h exp 1/c", bus.imem_req, bus.imem_addr);
        end
        tick;
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'hC || bus.imem_addr !== 32'h10) begin
            errors++; $display("FAIL stall_after: valid=%b pc_out=%h addr=%h exp 1/c/10", inst_valid, pc_out, bus.imem_addr);
        end
    endtask

    task automatic test_redirect_discard;
        apply_reset(1, 1'b1);
        repeat (5) tick;
        checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL disc_pre: addr=%h exp 10", bus.imem_addr); end
        mem_auto = 1'b0; man_ack = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h100;
        tick;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
            errors++; $display("FAIL disc_hold: req=%b addr=%h exp 1/10", bus.imem_req, bus.imem_addr);
        end
        checks++; if (inst_valid !== 1'b0 || inst_out !== 32'h0) begin
            errors++; $display("FAIL disc_flush: valid=%b inst=%h exp 0/0", inst_valid, inst_out);
        end
        redirect = 1'b0;
        tick;
        checks++; if (bus.imem_addr !== 32'h10 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL disc_wait: addr=%h valid=%b exp 10/0", bus.imem_addr, inst_valid);
        end
        man_ack = 1'b1;
        tick;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
            errors++; $display("FAIL disc_refetch: req=%b addr=%h exp 1/100", bus.imem_req, bus.imem_addr);
        end
        checks++; if (inst_valid !== 1'b0 || inst_out !== 32'h0) begin
            errors++; $display("FAIL disc_dropped: valid=%b inst=%h exp 0/0", inst_valid, inst_out);
        end
        man_ack = 1'b0;
        tick;
        checks++; if (inst_valid !== 1'b0 || bus.imem_addr !== 32'h100) begin
            errors++; $display("FAIL disc_pending: valid=%b addr=%h exp 0/100", inst_valid, bus.imem_addr);
        end
        man_ack = 1'b1;
        tick;
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h100 || inst_out !== 32'hA5A5_0100 || bus.imem_addr !== 32'h104) begin
            errors++; $display("FAIL disc_target: valid=%b pc_out=%h inst=%h addr=%h exp 1/100/a5a50100/104",
                               inst_valid, pc_out, inst_out, bus.imem_addr);
        end
        man_ack = 1'b0;
        tick;
        checks++; if (inst_valid !== 1'b0 || inst_out !== 32'hA5A5_0100) begin
            errors++; $display("FAIL disc_valid_drop: valid=%b inst=%h exp 0/a5a50100", inst_valid, inst_out);
        end
    endtask

    task automatic test_redirect_ack;
        apply_reset(1, 1'b1);
        repeat (9) tick;
        checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("FAIL rack_pre: addr=%h exp 20", bus.imem_addr); end
        redirect = 1'b1; redirect_pc = 32'h200;
        tick;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200 || inst_valid !== 1'b0 || inst_out !== 32'h0) begin
            errors++; $display("FAIL rack_redirect: req=%b addr=%h valid=%b inst=%h exp 1/200/0/0",
                               bus.imem_req, bus.imem_addr, inst_valid, inst_out);
        end
        redirect = 1'b0;
        tick;
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h200 || inst_out !== 32'hA5A5_0200 || bus.imem_addr !== 32'h204) begin
            errors++; $display("FAIL rack_target: valid=%b pc_out=%h inst=%h addr=%h exp 1/200/a5a50200/204",
                               inst_valid, pc_out, inst_out, bus.imem_addr);
        end
        stall = 1'b1;
        tick;
        checks++; if (bus.imem_req !== 1'b0 || inst_valid !== 1'b1 || pc_out !== 32'h200) begin
            errors++; $display("FAIL rack_skid_fill: req=%b valid=%b pc_out=%h exp 0/1/200", bus.imem_req, inst_valid, pc_out);
        end
        redirect = 1'b1; redirect_pc = 32'h300;
        tick;
        checks++; if (bus.imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_out !== 32'h0) begin
            errors++; $display("FAIL rack_stall_flush: req=%b valid=%b inst=%h exp 0/0/0", bus.imem_req, inst_valid, inst_out);
        end
        redirect = 1'b0; stall = 1'b0;
        tick;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL rack_skid_empty: req=%b addr=%h valid=%b exp 1/300/0", bus.imem_req, bus.imem_addr, inst_valid);
        end
        tick;
        checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h300 || inst_out !== 32'hA5A5_0300) begin
            errors++; $display("FAIL rack_new_target: valid=%b pc_out=%h inst=%h exp 1/300/a5a50300", inst_valid, pc_out, inst_out);
        end
    endtask

    task automatic test_wrap;
        apply_reset(1, 1'b1);
        tick;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick;
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC || inst_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_launch: addr=%h valid=%b exp fffffffc/0", bus.imem_addr, inst_valid);
        end
        redirect = 1'b0;
        tick;
        checks++; if (pc_out !== 32'hFFFF_FFFC || inst_out !== 32'h5A5A_FFFC || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_next: pc_out=%h inst=%h addr=%h exp fffffffc/5a5afffc/0", pc_out, inst_out, bus.imem_addr);
        end
        tick;
        checks++; if (pc_out !== 32'h0 || inst_valid !== 1'b1 || bus.imem_addr !== 32'h4) begin
            errors++; $display("FAIL wrap_after: pc_out=%h valid=%b addr=%h exp 0/1/4", pc_out, inst_valid, bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid;
        apply_reset(1, 1'b1);
        tick; tick; tick;
        checks++; if (pc_out !== 32'h4 || bus.imem_addr !== 32'h8) begin
            errors++; $display("FAIL rmid_pre: pc_out=%h addr=%h exp 4/8", pc_out, bus.imem_addr);
        end
        rst_if = 1'b1; mem_auto = 1'b0; man_ack = 1'b0;
        tick;
        checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || inst_out !== 32'h0 || pc_out !== 32'h0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_zero: req=%b addr=%h inst=%h pc_out=%h valid=%b exp all 0",
                               bus.imem_req, bus.imem_addr, inst_out, pc_out, inst_valid);
        end
        rst_if = 1'b0; man_ack = 1'b1;
        tick;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC || inst_valid !== 1'b0 || inst_out !== 32'h0) begin
            errors++; $display("FAIL rmid_stray_ack: req=%b addr=%h valid=%b inst=%h exp 1/%h/0/0",
                               bus.imem_req, bus.imem_addr, inst_valid, inst_out, RESET_PC);
        end
        man_ack = 1'b0;
        tick;
        checks++; if (bus.imem_addr !== RESET_PC || inst_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_wait: addr=%h valid=%b exp %h/0", bus.imem_addr, inst_valid, RESET_PC);
        end
        man_ack = 1'b1;
        tick;
        checks++; if (inst_valid !== 1'b1 || pc_out !== RESET_PC || inst_out !== (RESET_PC ^ 32'hA5A5_0000) || bus.imem_addr !== RESET_PC + 32'd4) begin
            errors++; $display("FAIL rmid_first: valid=%b pc_out=%h inst=%h addr=%h exp 1/%h/%h/%h",
                               inst_valid, pc_out, inst_out, bus.imem_addr, RESET_PC, RESET_PC ^ 32'hA5A5_0000, RESET_PC + 32'd4);
        end
        man_ack = 1'b0;
    endtask

    initial begin
        rst_if = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        man_ack = 1'b0; mem_auto = 1'b1; mem_lat = 1;
        @(negedge clk);
        test_reset;
        test_zero_wait;
        test_latency3;
        test_stall;
        test_redirect_discard;
        test_redirect_ack;
        test_wrap;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
